// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, width encodings, FSM state type and access-size helper
// for the load/store access controller.
package lsu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } lsuState_e;

  // Encoding 2'b10 is deliberately folded into word.
  function automatic logic [2:0] sizeFromWidth(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_access_ctrl_if.sv
// lsu_access_ctrl_if: execute-stage request/response handshake plus word-memory port.
// master = execute stage and memory; slave = access controller.
interface lsu_access_ctrl_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_width;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_width, req_sign, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_width, req_sign, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational shift, truncate and sign/zero extend of the
// 64-bit little-endian load window into a 32-bit write-back value.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0]       window,
  input  logic [1:0]        offset,
  input  logic [1:0]        width,
  input  logic              signExt,
  output logic [DATA_W-1:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(window >> {offset, 3'b000});
    case (width)
      WIDTH_BYTE: data = {{24{signExt & shifted[7]}}, shifted[7:0]};
      WIDTH_HALF: data = {{16{signExt & shifted[15]}}, shifted[15:0]};
      default:    data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: turns one byte/half/word load or store into one or two aligned word accesses.
// Macro LSU_MISALIGN_SPLIT_EN: defined splits word-crossing accesses; undefined flags them with resp_err.
//
// state | meaning
// IDLE  | ready, waiting for req_valid
// ACC0  | access to the word holding the first byte
// ACC1  | access to the following word; word 0 read data captured
// DONE  | one-cycle response pulse
module lsu_access_ctrl
  import lsu_pkg::*;
(
  input logic              CLK,
  input logic              Reset,
  lsu_access_ctrl_if.slave bus
);

  lsuState_e state, nextState;

  logic              reqWrite;
  logic              reqSign;
  logic [1:0]        reqWidth;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              crossReg;
  logic [DATA_W-1:0] holdLo;

  logic [2:0]        inSize;
  logic              inCross;
  logic              accept;
  logic [3:0]        sizeMask;
  logic [1:0]        offset;
  logic [ADDR_W-1:0] wordAddr;
  logic [63:0]       storeWin;
  logic [7:0]        beWin;
  logic [63:0]       loadWin;
  logic [DATA_W-1:0] loadData;
  logic              respErr;

  assign inSize  = sizeFromWidth(bus.req_width);
  assign inCross = ({2'b00, bus.req_addr[1:0]} + {1'b0, inSize}) > 4'd4;
  assign accept  = (state == IDLE) && bus.req_valid;

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      reqWrite <= 1'b0;
      reqSign  <= 1'b0;
      reqWidth <= WIDTH_BYTE;
      reqAddr  <= '0;
      reqWdata <= '0;
      crossReg <= 1'b0;
      holdLo   <= '0;
    end else begin
      if (accept) begin
        reqWrite <= bus.req_write;
        reqSign  <= bus.req_sign;
        reqWidth <= bus.req_width;
        reqAddr  <= bus.req_addr;
        reqWdata <= bus.req_wdata;
        crossReg <= inCross;
      end
      if (state == ACC1) holdLo <= bus.mem_rdata;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          nextState = ACC0;
`else
          nextState = inCross ? DONE : ACC0;
`endif
        end
      end
      ACC0:    nextState = crossReg ? ACC1 : DONE;
      ACC1:    nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    case (sizeFromWidth(reqWidth))
      3'd1:    sizeMask = 4'b0001;
      3'd2:    sizeMask = 4'b0011;
      default: sizeMask = 4'b1111;
    endcase
  end

  assign offset   = reqAddr[1:0];
  assign wordAddr = {reqAddr[ADDR_W-1:2], 2'b00};
  assign storeWin = {32'b0, reqWdata} << {offset, 3'b000};
  assign beWin    = {4'b0000, sizeMask} << offset;
  assign loadWin  = crossReg ? {bus.mem_rdata, holdLo} : {32'b0, bus.mem_rdata};

`ifdef LSU_MISALIGN_SPLIT_EN
  assign respErr = 1'b0;
`else
  assign respErr = crossReg;
`endif

  lsu_load_align u_load_align (
    .window  (loadWin),
    .offset  (offset),
    .width   (reqWidth),
    .signExt (reqSign),
    .data    (loadData)
  );

  // Outputs are gated by Reset so an aborted access stops driving memory immediately.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = 4'b0000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: bus.req_ready = 1'b1;
        ACC0: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = reqWrite;
          bus.mem_be    = beWin[3:0];
          bus.mem_addr  = wordAddr;
          bus.mem_wdata = reqWrite ? storeWin[31:0] : '0;
        end
        ACC1: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = reqWrite;
          bus.mem_be    = beWin[7:4];
          bus.mem_addr  = wordAddr + 32'd4;
          bus.mem_wdata = reqWrite ? storeWin[63:32] : '0;
        end
        DONE: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = respErr;
          bus.resp_rdata = (reqWrite || respErr) ? '0 : loadData;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// tb_lsu_access_ctrl: directed and randomized load/store transactions checked against
// a byte-level reference memory model; also covers reset behaviour.
module tb_lsu_access_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset = 1'b1;

  lsu_access_ctrl_if bus();

  lsu_access_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0] envMem [logic [31:0]];
  logic [7:0] refMem [logic [31:0]];

  function automatic logic [7:0] rdEnv(input logic [31:0] a);
    return envMem.exists(a) ? envMem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rdRef(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : 8'h00;
  endfunction

  // Word-organised memory: byte-enabled writes, read data one cycle after the access.
  always @(posedge CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) envMem[bus.mem_addr + 32'(i)] = bus.mem_wdata[8*i +: 8];
      end else begin
        bus.mem_rdata <= {rdEnv(bus.mem_addr + 32'd3), rdEnv(bus.mem_addr + 32'd2),
                          rdEnv(bus.mem_addr + 32'd1), rdEnv(bus.mem_addr)};
      end
    end
  end

  int          obsLat, obsRespCnt, obsAccCnt, obsReadyFirst;
  logic        obsErr;
  logic [31:0] obsRdata;
  logic [31:0] obsAddr [4];
  logic [3:0]  obsBe [4];
  logic        obsWe [4];
  logic [31:0] obsWdata [4];

  int          expLat, expAccCnt;
  logic        expErr;
  logic [31:0] expRdata;
  logic [31:0] expAddr [2];
  logic [3:0]  expBe [2];
  logic [31:0] expWdata [2];

  // Reference model: walks the accessed bytes one by one in a flat byte memory.
  task automatic predict(input bit w, input logic [1:0] wd, input bit sg,
                         input logic [31:0] a, input logic [31:0] d);
    int sz;
    int o;
    logic [31:0] base;
    logic [31:0] val;
    sz = (wd == 2'b00) ? 1 : (wd == 2'b01) ? 2 : 4;
    o = int'(a[1:0]);
    base = a & 32'hFFFF_FFFC;
    for (int j = 0; j < 2; j++) begin
      expBe[j] = 4'b0000;
      expWdata[j] = 32'h0;
      expAddr[j] = base + 32'(4 * j);
    end
    expRdata = 32'h0;
    if ((o + sz > 4) && !SPLIT) begin
      expLat = 1; expErr = 1'b1; expAccCnt = 0;
      return;
    end
    expErr = 1'b0;
    expAccCnt = (o + sz > 4) ? 2 : 1;
    expLat = expAccCnt + 1;
    val = 32'h0;
    for (int i = 0; i < sz; i++) begin
      logic [31:0] ba;
      int wi;
      ba = a + 32'(i);
      wi = (ba[31:2] != base[31:2]) ? 1 : 0;
      expBe[wi][ba[1:0]] = 1'b1;
      if (w) begin
        expWdata[wi][8*ba[1:0] +: 8] = d[8*i +: 8];
        refMem[ba] = d[8*i +: 8];
      end else begin
        val[8*i +: 8] = rdRef(ba);
      end
    end
    if (!w) begin
      expRdata = val;
      if (sg && sz < 4 && val[8*sz-1]) expRdata = val - (32'd1 << (8 * sz));
    end
  endtask

  task automatic driveTxn(input bit w, input logic [1:0] wd, input bit sg,
                          input logic [31:0] a, input logic [31:0] d);
    int waitCnt;
    waitCnt = 0;
    @(negedge CLK);
    while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
      @(negedge CLK);
      waitCnt++;
    end
    if (bus.req_ready !== 1'b1) begin
      nCompared++; nMismatched++;
      $display("FAIL ready_timeout: req_ready=%b required 1 within 20 cycles", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_width = wd;
    bus.req_sign  = sg;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_width = 2'($urandom);
    bus.req_sign  = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    obsLat = 0; obsRespCnt = 0; obsAccCnt = 0; obsReadyFirst = 0;
    obsErr = 1'b0; obsRdata = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (bus.mem_en === 1'b1) begin
        if (obsAccCnt < 4) begin
          obsAddr[obsAccCnt]  = bus.mem_addr;
          obsBe[obsAccCnt]    = bus.mem_be;
          obsWe[obsAccCnt]    = bus.mem_we;
          obsWdata[obsAccCnt] = bus.mem_wdata;
        end
        obsAccCnt++;
      end
      if (bus.resp_valid === 1'b1) begin
        obsRespCnt++;
        if (obsLat == 0) begin
          obsLat = k; obsErr = bus.resp_err; obsRdata = bus.resp_rdata;
        end
      end
      if (bus.req_ready === 1'b1 && obsReadyFirst == 0) obsReadyFirst = k;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    nCompared++;
    if (bus.req_ready !== 1'b0) begin
      nMismatched++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
    end
    nCompared++;
    if ({bus.mem_en, bus.mem_we, bus.resp_valid, bus.resp_err} !== 4'b0000) begin
      nMismatched++;
      $display("FAIL reset_ctrl: en/we/valid/err got %b want 0000",
               {bus.mem_en, bus.mem_we, bus.resp_valid, bus.resp_err});
    end
    nCompared++;
    if ({bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.resp_rdata} !== 100'h0) begin
      nMismatched++;
      $display("FAIL reset_data: be=%b addr=%h wdata=%h rdata=%h want all 0",
               bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.resp_rdata);
    end
    Reset = 1'b0;
    @(negedge CLK);
    nCompared++;
    if (bus.req_ready !== 1'b1) begin
      nMismatched++; $display("FAIL ready_after_reset: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_store_byte();
    predict(1'b1, 2'b00, 1'b0, 32'h13, 32'hA1);
    driveTxn(1'b1, 2'b00, 1'b0, 32'h13, 32'hA1);
    nCompared++;
    if (obsAccCnt !== 1 || obsLat !== 2) begin
      nMismatched++; $display("FAIL sb_timing: acc=%0d lat=%0d want acc=1 lat=2", obsAccCnt, obsLat);
    end
    nCompared++;
    if (obsAddr[0] !== 32'h10 || obsBe[0] !== 4'b1000 || obsWe[0] !== 1'b1) begin
      nMismatched++;
      $display("FAIL sb_access: addr=%h be=%b we=%b want 00000010 1000 1", obsAddr[0], obsBe[0], obsWe[0]);
    end
    nCompared++;
    if (obsWdata[0] !== 32'hA100_0000) begin
      nMismatched++; $display("FAIL sb_wdata: got %h want a1000000", obsWdata[0]);
    end
  endtask

  task automatic test_load_byte();
    predict(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    driveTxn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    nCompared++;
    if (obsRdata !== 32'h0000_00A1 || obsLat !== 2 || obsErr !== 1'b0) begin
      nMismatched++;
      $display("FAIL lbu: rdata=%h lat=%0d err=%b want 000000a1 2 0", obsRdata, obsLat, obsErr);
    end
    predict(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    driveTxn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    nCompared++;
    if (obsRdata !== 32'hFFFF_FFA1) begin
      nMismatched++; $display("FAIL lb_signed: got %h want ffffffa1", obsRdata);
    end
    nCompared++;
    if (obsWe[0] !== 1'b0 || obsBe[0] !== 4'b1000) begin
      nMismatched++; $display("FAIL lb_access: we=%b be=%b want 0 1000", obsWe[0], obsBe[0]);
    end
  endtask

  task automatic test_half();
    predict(1'b1, 2'b01, 1'b0, 32'h11, 32'hA1A1);
    driveTxn(1'b1, 2'b01, 1'b0, 32'h11, 32'hA1A1);
    nCompared++;
    if (obsAccCnt !== 1 || obsBe[0] !== 4'b0110 || obsWdata[0] !== 32'h00A1_A100) begin
      nMismatched++;
      $display("FAIL sh: acc=%0d be=%b wdata=%h want 1 0110 00a1a100", obsAccCnt, obsBe[0], obsWdata[0]);
    end
    predict(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
    driveTxn(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
    nCompared++;
    if (obsRdata !== 32'hFFFF_A1A1) begin
      nMismatched++; $display("FAIL lh_signed: got %h want ffffa1a1", obsRdata);
    end
  endtask

  task automatic test_split();
`ifdef LSU_MISALIGN_SPLIT_EN
    predict(1'b1, 2'b11, 1'b0, 32'h12, 32'h00A1_A1A1);
    driveTxn(1'b1, 2'b11, 1'b0, 32'h12, 32'h00A1_A1A1);
    nCompared++;
    if (obsAccCnt !== 2 || obsAddr[0] !== 32'h10 || obsBe[0] !== 4'b1100 || obsWdata[0] !== 32'hA1A1_0000) begin
      nMismatched++;
      $display("FAIL sw_split_w0: acc=%0d addr=%h be=%b wdata=%h want 2 00000010 1100 a1a10000",
               obsAccCnt, obsAddr[0], obsBe[0], obsWdata[0]);
    end
    nCompared++;
    if (obsAddr[1] !== 32'h14 || obsBe[1] !== 4'b0011 || obsWdata[1] !== 32'h0000_00A1) begin
      nMismatched++;
      $display("FAIL sw_split_w1: addr=%h be=%b wdata=%h want 00000014 0011 000000a1",
               obsAddr[1], obsBe[1], obsWdata[1]);
    end
    predict(1'b0, 2'b11, 1'b0, 32'h12, 32'h0);
    driveTxn(1'b0, 2'b11, 1'b0, 32'h12, 32'h0);
    nCompared++;
    if (obsRdata !== 32'h00A1_A1A1 || obsLat !== 3 || obsReadyFirst !== 4) begin
      nMismatched++;
      $display("FAIL lw_split: rdata=%h lat=%0d ready=%0d want 00a1a1a1 3 4", obsRdata, obsLat, obsReadyFirst);
    end
`else
    predict(1'b0, 2'b11, 1'b0, 32'h12, 32'h0);
    driveTxn(1'b0, 2'b11, 1'b0, 32'h12, 32'h0);
    nCompared++;
    if (obsLat !== 1 || obsErr !== 1'b1 || obsRdata !== 32'h0) begin
      nMismatched++;
      $display("FAIL lw_cross_err: lat=%0d err=%b rdata=%h want 1 1 00000000", obsLat, obsErr, obsRdata);
    end
    nCompared++;
    if (obsAccCnt !== 0 || obsReadyFirst !== 2) begin
      nMismatched++;
      $display("FAIL lw_cross_noacc: acc=%0d ready=%0d want 0 2", obsAccCnt, obsReadyFirst);
    end
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'hFFFF_FFFE + 32'(i);
      d = 32'(8'h11 * (i + 1));
      predict(1'b1, 2'b00, 1'b0, a, d);
      driveTxn(1'b1, 2'b00, 1'b0, a, d);
    end
    predict(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0);
    driveTxn(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    nCompared++;
    if (obsAccCnt !== 2 || obsAddr[0] !== 32'hFFFF_FFFC || obsAddr[1] !== 32'h0) begin
      nMismatched++;
      $display("FAIL wrap_addr: acc=%0d a0=%h a1=%h want 2 fffffffc 00000000", obsAccCnt, obsAddr[0], obsAddr[1]);
    end
    nCompared++;
    if (obsRdata !== 32'h4433_2211) begin
      nMismatched++; $display("FAIL wrap_rdata: got %h want 44332211", obsRdata);
    end
`else
    nCompared++;
    if (obsErr !== 1'b1 || obsAccCnt !== 0) begin
      nMismatched++; $display("FAIL wrap_err: err=%b acc=%0d want 1 0", obsErr, obsAccCnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit w;
      bit sg;
      logic [1:0] wd;
      logic [31:0] a;
      logic [31:0] d;
      w  = 1'($urandom);
      sg = 1'($urandom);
      wd = 2'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31))
                                       : 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      d  = $urandom;
      if (wd == 2'b00) d = d & 32'h0000_00FF;
      else if (wd == 2'b01) d = d & 32'h0000_FFFF;
      predict(w, wd, sg, a, d);
      driveTxn(w, wd, sg, a, d);
      nCompared++;
      if (obsLat !== expLat || obsRespCnt !== 1 || obsReadyFirst !== expLat + 1) begin
        nMismatched++;
        $display("FAIL rnd_timing #%0d: lat=%0d pulses=%0d ready=%0d want %0d 1 %0d",
                 n, obsLat, obsRespCnt, obsReadyFirst, expLat, expLat + 1);
      end
      nCompared++;
      if (obsErr !== expErr || obsRdata !== expRdata) begin
        nMismatched++;
        $display("FAIL rnd_resp #%0d (w=%0d wd=%b sg=%0d a=%h): err=%b rdata=%h want %b %h",
                 n, w, wd, sg, a, obsErr, obsRdata, expErr, expRdata);
      end
      nCompared++;
      if (obsAccCnt !== expAccCnt) begin
        nMismatched++; $display("FAIL rnd_acc_cnt #%0d: got %0d want %0d", n, obsAccCnt, expAccCnt);
      end
      for (int j = 0; j < expAccCnt && j < obsAccCnt; j++) begin
        nCompared++;
        if (obsAddr[j] !== expAddr[j] || obsBe[j] !== expBe[j] || obsWe[j] !== w) begin
          nMismatched++;
          $display("FAIL rnd_access #%0d.%0d: addr=%h be=%b we=%b want %h %b %b",
                   n, j, obsAddr[j], obsBe[j], obsWe[j], expAddr[j], expBe[j], w);
        end
        if (w) begin
          nCompared++;
          if (obsWdata[j] !== expWdata[j]) begin
            nMismatched++;
            $display("FAIL rnd_wdata #%0d.%0d: got %h want %h", n, j, obsWdata[j], expWdata[j]);
          end
        end
      end
    end
  endtask

  // Abort a load in its last access cycle (ACC1 when splitting, ACC0 otherwise).
  task automatic test_reset_mid();
    int seenResp;
    int seenEn;
    int target;
    target = SPLIT ? 2 : 1;
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_width = 2'b11;
    bus.req_sign  = 1'b0;
    bus.req_addr  = SPLIT ? 32'h12 : 32'h10;
    bus.req_wdata = 32'h0;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    repeat (target) @(negedge CLK);
    nCompared++;
    if (bus.mem_en !== 1'b1) begin
      nMismatched++; $display("FAIL rst_mid_pre: mem_en=%b want 1", bus.mem_en);
    end
    Reset = 1'b1;
    #1;
    nCompared++;
    if (bus.mem_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
      nMismatched++;
      $display("FAIL rst_mid_gate: mem_en=%b resp_valid=%b want 0 0", bus.mem_en, bus.resp_valid);
    end
    @(negedge CLK);
    nCompared++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
      nMismatched++;
      $display("FAIL rst_mid_held: ready=%b valid=%b en=%b want 0 0 0", bus.req_ready, bus.resp_valid, bus.mem_en);
    end
    Reset = 1'b0;
    seenResp = 0;
    seenEn = 0;
    @(negedge CLK);
    nCompared++;
    if (bus.req_ready !== 1'b1) begin
      nMismatched++; $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid === 1'b1) seenResp++;
      if (bus.mem_en === 1'b1) seenEn++;
      @(negedge CLK);
    end
    nCompared++;
    if (seenResp !== 0 || seenEn !== 0) begin
      nMismatched++;
      $display("FAIL rst_mid_drop: resp pulses=%0d accesses=%0d want 0 0", seenResp, seenEn);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_width = 2'b00;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    test_reset();
    test_store_byte();
    test_load_byte();
    test_half();
    test_split();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/lsu_access_ctrl.md
# lsu_access_ctrl

Load/store access controller between the execute stage and the word-organised data memory, which it drives through a byte-enable port. Accepts one load or store per handshake, with width byte, halfword or word and signed or unsigned load. Converts the request into one or two aligned word accesses, splitting when the access crosses a word boundary. Merges and extends load data into a 32-bit write-back value.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; fixed at 32
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle and can accept
- req_write  in  1  1 = store, 0 = load
- req_width  in  2  00 byte, 01 halfword, 11 word; 10 treated as word
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse, loads and stores
- resp_rdata  out  DATA_W  load result; 0 for stores and errors
- resp_err  out  1  misaligned-access error; valid with resp_valid
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables; bit i = byte lane [8i+7:8i]
- mem_addr  out  ADDR_W  word-aligned address; low 2 bits always 0
- mem_wdata  out  DATA_W  lane-aligned store data
- mem_rdata  in  DATA_W  read data, valid the cycle after a read access

## Operation
- Memory is little-endian. For offset o = addr[1:0]: size = 1, 2 or 4 bytes. A request crosses a word boundary when o + size > 4.
- States:
  - IDLE: req_ready = 1. On req_valid, capture the request and go to ACC0.
  - ACC0: issue word 0, at addr & ~3. If crossing, go to ACC1; otherwise go to DONE.
  - ACC1: issue word 1, at (addr & ~3) + 4, modulo 2^32. Capture mem_rdata (word 0) into hold_lo. Go to DONE.
  - DONE: resp_valid = 1. Go to IDLE.
- Store data and enables:
  - Form S = zero-extended data << 8·o, a 64-bit value.
  - mem_wdata is S[31:0] for word 0 and S[63:32] for word 1.
  - mem_be is the matching slice of the size-mask << o.
- Load data:
  - In DONE, form {mem_rdata, hold_lo} for a split access, or {0, mem_rdata} otherwise.
  - Shift right by 8·o, truncate to size, then sign- or zero-extend per req_sign.
  - resp_rdata is combinational in DONE and 0 in all other states.
- Request inputs need only be valid in the accept cycle.
- Width 10 is never flagged as an error.

## Timing
- Reset values: state IDLE; mem_en, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err all 0.
- req_ready is 0 while Reset is high and 1 after it.
- Accept on edge T. Non-crossing access: ACC0 in cycle T+1, resp_valid in T+2. Crossing access: resp_valid in T+3.
- The next request can be accepted no earlier than the cycle after DONE.
- Reset asserted in any state: IDLE at the next edge. The outstanding response is dropped and mem_en is 0 from that cycle.
- mem_en is never asserted outside ACC0 and ACC1.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: crossing accesses are split as above. resp_err is tied to 0.
- LSU_MISALIGN_SPLIT_EN undefined: a crossing request goes from IDLE directly to DONE with resp_err = 1 and resp_rdata = 0. No memory access is issued. Non-crossing accesses are unchanged.

## Structure
- lsu_pkg holds:
  - width encodings WIDTH_BYTE = 2'b00, WIDTH_HALF = 2'b01, WIDTH_WORD = 2'b11;
  - the state enum (IDLE, ACC0, ACC1, DONE);
  - a size-from-width function.
- Sub-module lsu_load_align: purely combinational shift, truncate and extend of the 64-bit load window. It is instantiated once.

## Test plan
- Store byte 0xa1 at 0x13 → one access: mem_addr 0x10, mem_be 1000, mem_wdata 0xa1000000. resp_valid at T+2.
- Load byte unsigned at 0x13 after the above → resp_rdata 0x000000a1. Signed → 0xffffffa1.
- Store halfword 0xa1a1 at 0x11 → single access with be 0110, wdata 0x00a1a100. Signed load → 0xffffa1a1.
- With the macro, store word 0x00a1a1a1 at 0x12:
  - first access: addr 0x10, be 1100, wdata 0xa1a10000;
  - second access: addr 0x14, be 0011, wdata 0x000000a1.
  - Load word at 0x12 → 0x00a1a1a1 at T+3.
- Without the macro, load word at 0x12 → resp_valid at T+1 with resp_err 1, mem_en never asserted.
- Word load at 0xfffffffe → second access at 0x00000000. Reset pulsed during ACC1 → IDLE next edge, no resp_valid, req_ready 1 after Reset falls.
